// File: rtl/wbs_mem_bridge.sv
// Wishbone slave bridging the management bus to the KD-tree accelerator core.
// Decodes control registers, node writes, two-beat 64-bit leaf/query writes and
// two-beat 64-bit best-array reads. Every accepted cycle gets a one-cycle ack.
module wbs_mem_bridge #(
  parameter int unsigned NODE_AW  = 6,
  parameter int unsigned LEAF_AW  = 9,
  parameter int unsigned QUERY_AW = 9,
  parameter int unsigned BEST_AW  = 9
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                fsm_busy_i,
  input  logic                fsm_done_i,
  output logic                mode_o,
  output logic                debug_o,
  output logic                fsm_start_o,
  output logic                node_wen_o,
  output logic [NODE_AW-1:0]  node_addr_o,
  output logic [21:0]         node_wdata_o,
  output logic                leaf_wen_o,
  output logic [LEAF_AW-1:0]  leaf_addr_o,
  output logic [63:0]         leaf_wdata_o,
  output logic                query_wen_o,
  output logic [QUERY_AW-1:0] query_addr_o,
  output logic [63:0]         query_wdata_o,
  output logic                best_ren_o,
  output logic [BEST_AW-1:0]  best_addr_o,
  input  logic [63:0]         best_rdata_i
);

  localparam logic [31:0] RegionCtrl  = 32'h3000_0000;
  localparam logic [31:0] RegionQuery = 32'h3001_0000;
  localparam logic [31:0] RegionLeaf  = 32'h3002_0000;
  localparam logic [31:0] RegionBest  = 32'h3003_0000;
  localparam logic [31:0] RegionNode  = 32'h3004_0000;

  // StRdData covers the cycle in which the SRAM presents the requested word.
  typedef enum logic [1:0] {StIdle, StRdWait, StRdData, StAck} state_e;

  state_e      state;
  logic [31:0] hold_lo;
  logic        best_hi;

  logic        req;
  logic [31:0] region;
  logic [7:0]  offset;
  logic        is_ctrl, is_query, is_leaf, is_best, is_node;
  logic [31:0] ctrl_rdata;
  logic        unused_bits;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign region   = wbs_adr_i & 32'hFFFF_0000;
  assign offset   = wbs_adr_i[7:0];
  assign is_ctrl  = (region == RegionCtrl);
  assign is_query = (region == RegionQuery);
  assign is_leaf  = (region == RegionLeaf);
  assign is_best  = (region == RegionBest);
  assign is_node  = (region == RegionNode);

  // Byte selects are ignored; writes are always full-word.
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  // Control register read mux; unused offsets and bits read as zero.
  always_comb begin
    ctrl_rdata = 32'h0;
    case (offset)
      8'h00:   ctrl_rdata = {31'h0, mode_o};
      8'h04:   ctrl_rdata = {31'h0, debug_o};
      8'h08:   ctrl_rdata = {31'h0, fsm_done_i};
      8'h10:   ctrl_rdata = {31'h0, fsm_busy_i};
      default: ctrl_rdata = 32'h0;
    endcase
  end

  // Transaction FSM with registered ack, read data, strobes and register bits.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      hold_lo       <= 32'h0;
      best_hi       <= 1'b0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= 32'h0;
      mode_o        <= 1'b0;
      debug_o       <= 1'b0;
      fsm_start_o   <= 1'b0;
      node_wen_o    <= 1'b0;
      node_addr_o   <= '0;
      node_wdata_o  <= 22'h0;
      leaf_wen_o    <= 1'b0;
      leaf_addr_o   <= '0;
      leaf_wdata_o  <= 64'h0;
      query_wen_o   <= 1'b0;
      query_addr_o  <= '0;
      query_wdata_o <= 64'h0;
      best_ren_o    <= 1'b0;
      best_addr_o   <= '0;
    end else begin
      // Pulses default low; set for exactly one cycle below.
      wbs_ack_o   <= 1'b0;
      fsm_start_o <= 1'b0;
      node_wen_o  <= 1'b0;
      leaf_wen_o  <= 1'b0;
      query_wen_o <= 1'b0;
      best_ren_o  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req) begin
            if (is_best && !wbs_we_i) begin
              best_ren_o  <= 1'b1;
              best_addr_o <= wbs_adr_i[BEST_AW+2:3];
              best_hi     <= wbs_adr_i[2];
              state       <= StRdWait;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= StAck;
              if (!wbs_we_i) begin
                wbs_dat_o <= is_ctrl ? ctrl_rdata : 32'h0;
              end else if (is_ctrl) begin
                if (offset == 8'h00 && !fsm_busy_i) mode_o <= wbs_dat_i[0];
                if (offset == 8'h04) debug_o <= wbs_dat_i[0];
                if (offset == 8'h0C) fsm_start_o <= 1'b1;
              end else if (!fsm_busy_i) begin
                if (is_node) begin
                  node_wen_o   <= 1'b1;
                  node_addr_o  <= wbs_adr_i[NODE_AW+1:2];
                  node_wdata_o <= wbs_dat_i[21:0];
                end else if ((is_leaf || is_query) && !wbs_adr_i[2]) begin
                  hold_lo <= wbs_dat_i;
                end else if (is_leaf) begin
                  leaf_wen_o   <= 1'b1;
                  leaf_addr_o  <= wbs_adr_i[LEAF_AW+2:3];
                  leaf_wdata_o <= {wbs_dat_i, hold_lo};
                end else if (is_query) begin
                  query_wen_o   <= 1'b1;
                  query_addr_o  <= wbs_adr_i[QUERY_AW+2:3];
                  query_wdata_o <= {wbs_dat_i, hold_lo};
                end
              end
            end
          end
        end
        StRdWait: state <= StRdData;
        StRdData: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= best_hi ? best_rdata_i[63:32] : best_rdata_i[31:0];
          state     <= StAck;
        end
        StAck:    state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_mem_bridge.sv
// Directed self-checking bench for wbs_mem_bridge.
module tb_wbs_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        busy, done;
  logic        mode, debug, start;
  logic        node_wen;
  logic [5:0]  node_addr;
  logic [21:0] node_wdata;
  logic        leaf_wen;
  logic [8:0]  leaf_addr;
  logic [63:0] leaf_wdata;
  logic        query_wen;
  logic [8:0]  query_addr;
  logic [63:0] query_wdata;
  logic        best_ren;
  logic [8:0]  best_addr;
  logic [63:0] best_rdata;

  always #5 clk = ~clk;

  wbs_mem_bridge dut (
    .wb_clk_i      (clk),
    .rst_n         (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .fsm_busy_i    (busy),
    .fsm_done_i    (done),
    .mode_o        (mode),
    .debug_o       (debug),
    .fsm_start_o   (start),
    .node_wen_o    (node_wen),
    .node_addr_o   (node_addr),
    .node_wdata_o  (node_wdata),
    .leaf_wen_o    (leaf_wen),
    .leaf_addr_o   (leaf_addr),
    .leaf_wdata_o  (leaf_wdata),
    .query_wen_o   (query_wen),
    .query_addr_o  (query_addr),
    .query_wdata_o (query_wdata),
    .best_ren_o    (best_ren),
    .best_addr_o   (best_addr),
    .best_rdata_i  (best_rdata)
  );

  // Best SRAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (best_ren) begin
      if (best_addr == 9'd7) best_rdata <= 64'hAAAA5555_12345678;
      else                   best_rdata <= {32'hC0DE0000, 23'h0, best_addr};
    end
  end

  // Strobe monitors sampled mid-cycle.
  int node_cnt = 0, leaf_cnt = 0, query_cnt = 0, ren_cnt = 0, start_cnt = 0, b2b_cnt = 0;
  logic [8:0] ren_addr_last = '0;
  logic       prev_ack = 1'b0;
  always @(negedge clk) begin
    if (node_wen)  node_cnt++;
    if (leaf_wen)  leaf_cnt++;
    if (query_wen) query_cnt++;
    if (start)     start_cnt++;
    if (best_ren) begin
      ren_cnt++;
      ren_addr_last = best_addr;
    end
    if (ack && prev_ack) b2b_cnt++;
    prev_ack = ack;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction from an idle bus; returns read data and ack latency in edges.
  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                           output logic [31:0] rd, output int lat);
    @(posedge clk);
    @(negedge clk);
    adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    rd  = 32'hx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = i;
        rd  = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat == 0) check("ack_timeout", {63'h0, ack}, 64'h1);
  endtask

  logic [31:0] rd;
  int          lat;
  int          n0, l0, q0, r0, s0;
  logic [5:0]  pattern;

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; wdat = '0; busy = 1'b0; done = 1'b0; best_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {56'h0, ack, node_wen, leaf_wen, query_wen, best_ren, start, mode, debug},
          64'h0);
    check("reset_rdat", {32'h0, rdat}, 64'h0);
    check("reset_leaf_wdata", leaf_wdata, 64'h0);
    check("reset_query_wdata", query_wdata, 64'h0);
    check("reset_addrs", {22'h0, node_addr, leaf_addr, query_addr, best_addr}, 64'h0);
    check("reset_node_wdata", {42'h0, node_wdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Node write
    wb_access(32'h3004_0008, {10'b0, 11'd55, 11'd1}, 1'b1, rd, lat);
    check("node_lat", lat, 1);
    check("node_wen", {63'h0, node_wen}, 64'h1);
    check("node_addr", {58'h0, node_addr}, 64'd2);
    check("node_wdata", {42'h0, node_wdata}, 64'h1B801);
    @(posedge clk);
    #1;
    check("node_wen_drop", {62'h0, node_wen, ack}, 64'h0);

    // Leaf two-beat write
    l0 = leaf_cnt;
    wb_access(32'h3002_0018, 32'hDEADBEEF, 1'b1, rd, lat);
    check("leaf_lo_nowen", {63'h0, leaf_wen}, 64'h0);
    wb_access(32'h3002_001C, 32'h01234567, 1'b1, rd, lat);
    check("leaf_wen", {63'h0, leaf_wen}, 64'h1);
    check("leaf_addr", {55'h0, leaf_addr}, 64'd3);
    check("leaf_wdata", leaf_wdata, 64'h01234567_DEADBEEF);
    repeat (2) @(posedge clk);
    check("leaf_count", leaf_cnt - l0, 1);

    // Query two-beat write
    q0 = query_cnt;
    wb_access(32'h3001_0018, 32'hDEADBEEF, 1'b1, rd, lat);
    wb_access(32'h3001_001C, 32'h01234567, 1'b1, rd, lat);
    check("query_wen", {63'h0, query_wen}, 64'h1);
    check("query_addr", {55'h0, query_addr}, 64'd3);
    check("query_wdata", query_wdata, 64'h01234567_DEADBEEF);
    repeat (2) @(posedge clk);
    check("query_count", query_cnt - q0, 1);

    // Best reads, both halves, each re-reading the SRAM
    r0 = ren_cnt;
    wb_access(32'h3003_0038, 32'h0, 1'b0, rd, lat);
    check("best_lo_lat", lat, 3);
    check("best_lo_data", {32'h0, rd}, 64'h12345678);
    check("best_ren_addr", {55'h0, ren_addr_last}, 64'd7);
    wb_access(32'h3003_003C, 32'h0, 1'b0, rd, lat);
    check("best_hi_data", {32'h0, rd}, 64'hAAAA5555);
    check("best_ren_count", ren_cnt - r0, 2);

    // Control registers
    wb_access(32'h3000_0000, 32'h1, 1'b1, rd, lat);
    wb_access(32'h3000_0004, 32'h1, 1'b1, rd, lat);
    check("mode_debug", {62'h0, mode, debug}, 64'h3);
    wb_access(32'h3000_0000, 32'h0, 1'b0, rd, lat);
    check("mode_read", {32'h0, rd}, 64'h1);
    check("reg_read_lat", lat, 1);
    wb_access(32'h3000_0004, 32'h0, 1'b0, rd, lat);
    check("debug_read", {32'h0, rd}, 64'h1);
    s0 = start_cnt;
    wb_access(32'h3000_000C, 32'h5A, 1'b1, rd, lat);
    check("start_pulse", {63'h0, start}, 64'h1);
    @(posedge clk);
    #1;
    check("start_drop", {63'h0, start}, 64'h0);
    check("start_count", start_cnt - s0, 1);
    wb_access(32'h3000_000C, 32'h0, 1'b0, rd, lat);
    check("start_read", {32'h0, rd}, 64'h0);

    // Status registers
    busy = 1'b1; done = 1'b1;
    wb_access(32'h3000_0010, 32'h0, 1'b0, rd, lat);
    check("busy_read", {32'h0, rd}, 64'h1);
    wb_access(32'h3000_0008, 32'h0, 1'b0, rd, lat);
    check("done_read", {32'h0, rd}, 64'h1);

    // Busy gating: writes dropped but acked; DEBUG and start still act
    n0 = node_cnt; l0 = leaf_cnt; s0 = start_cnt;
    wb_access(32'h3004_0010, 32'h3FF, 1'b1, rd, lat);
    check("busy_node_lat", lat, 1);
    wb_access(32'h3002_0000, 32'h11111111, 1'b1, rd, lat);
    wb_access(32'h3002_0004, 32'h22222222, 1'b1, rd, lat);
    check("busy_leaf_lat", lat, 1);
    wb_access(32'h3000_0000, 32'h0, 1'b1, rd, lat);
    check("busy_mode_lat", lat, 1);
    check("busy_mode_kept", {63'h0, mode}, 64'h1);
    wb_access(32'h3000_0004, 32'h0, 1'b1, rd, lat);
    check("busy_debug_write", {63'h0, debug}, 64'h0);
    wb_access(32'h3000_000C, 32'h0, 1'b1, rd, lat);
    repeat (2) @(posedge clk);
    check("busy_node_count", node_cnt - n0, 0);
    check("busy_leaf_count", leaf_cnt - l0, 0);
    check("busy_start_count", start_cnt - s0, 1);
    busy = 1'b0; done = 1'b0;

    // hold_lo was untouched by the gated lower beat
    wb_access(32'h3002_0024, 32'hCAFEF00D, 1'b1, rd, lat);
    check("hold_kept_addr", {55'h0, leaf_addr}, 64'd4);
    check("hold_kept_wdata", leaf_wdata, 64'hCAFEF00D_DEADBEEF);

    // Unmapped region and write-only region reads return 0
    wb_access(32'h3000_0000, 32'h0, 1'b0, rd, lat);
    check("mode_reread", {32'h0, rd}, 64'h1);
    wb_access(32'h3007_0000, 32'h0, 1'b0, rd, lat);
    check("unmapped_lat", lat, 1);
    check("unmapped_read", {32'h0, rd}, 64'h0);
    wb_access(32'h3000_0000, 32'h0, 1'b0, rd, lat);
    wb_access(32'h3004_0000, 32'h0, 1'b0, rd, lat);
    check("node_read", {32'h0, rd}, 64'h0);

    // Strobe held for 6 cycles: re-accepted every other cycle
    n0 = node_cnt;
    @(posedge clk);
    @(negedge clk);
    adr = 32'h3004_000C; wdat = 32'h5; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pattern = {pattern[4:0], ack};
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("held_stb_acks", {58'h0, pattern}, 64'b101010);
    repeat (2) @(posedge clk);
    check("held_stb_writes", node_cnt - n0, 3);

    // Asynchronous reset mid-pulse
    wb_access(32'h3004_0004, 32'h7, 1'b1, rd, lat);
    check("pre_reset_pulse", {62'h0, node_wen, ack}, 64'h3);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_flags",
          {56'h0, ack, node_wen, leaf_wen, query_wen, best_ren, start, mode, debug}, 64'h0);
    check("async_reset_data", {node_wdata, rdat}, 64'h0);
    check("async_reset_wdata", leaf_wdata | query_wdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_access(32'h3000_0000, 32'h0, 1'b0, rd, lat);
    check("post_reset_mode", {32'h0, rd}, 64'h0);
    check("no_back_to_back_ack", b2b_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
